y86_dmem_responder: RTL

//  Memory-side responder for the Y86 CPU data-memory port. Holds the word array and serves one

---
 rtl/y86_dmem_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/y86_dmem_responder.sv
// Y86 data-memory responder: word array behind valid/ready request/response channels with
// programmable latency. Define Y86_DMEM_MISALIGN_EN to enable split (misaligned) accesses.
module y86_dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [63:0] req_addr_i,
    input  logic [63:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [63:0] rsp_rdata_o,
    output logic        rsp_error_o
);
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [63:0] TOP_ADDR = 64'(DEPTH_WORDS) * 64'd8 - 64'd8;
    localparam logic [3:0]  LAST_CNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, SPLIT, WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg, cnt_next;
    logic        rsp_valid_reg, rsp_error_reg, load_ok_reg;
    logic [63:0] rd_word_reg;
    logic [63:0] load_word;

    logic [63:0] mem [DEPTH_WORDS];

    logic          accept, misaligned, out_of_range, req_error;
    logic [AW-1:0] req_word;
    logic [5:0]    req_shift;

    logic          wr_en, rd_en;
    logic [AW-1:0] wr_idx, rd_idx;
    logic [63:0]   wr_data, wr_mask;

    assign req_ready_o  = (state_reg == IDLE) && !rst_i;
    assign accept       = req_valid_i && req_ready_o;
    assign req_word     = req_addr_i[AW+2:3];
    assign req_shift    = {req_addr_i[2:0], 3'b000};
    assign misaligned   = |req_addr_i[2:0];
    // Full 64-bit compare: nothing above the top of memory aliases back into it.
    assign out_of_range = req_addr_i > TOP_ADDR;
`ifdef Y86_DMEM_MISALIGN_EN
    assign req_error    = out_of_range;
`else
    assign req_error    = out_of_range || misaligned;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    cnt_next   = '0;
                    state_next = WAIT;
`ifdef Y86_DMEM_MISALIGN_EN
                    if (misaligned && !req_error) begin
                        state_next = SPLIT;
                    end
`endif
                end
            end
`ifdef Y86_DMEM_MISALIGN_EN
            SPLIT: begin
                cnt_next   = '0;
                state_next = WAIT;
            end
`endif
            WAIT: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_reg <= 1'b0;
            rsp_error_reg <= 1'b0;
            load_ok_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= (state_next == RESP);
            if (accept) begin
                rsp_error_reg <= req_error;
                load_ok_reg   <= !req_we_i && !req_error;
            end
        end
    end

`ifdef Y86_DMEM_MISALIGN_EN
    logic [2:0]    off_reg;
    logic [AW-1:0] hi_idx_reg;
    logic [63:0]   wdata_reg, lo_reg;
    logic          we_reg;
    logic [127:0]  pair_shifted;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            off_reg    <= req_addr_i[2:0];
            hi_idx_reg <= req_word + 1'b1;
            wdata_reg  <= req_wdata_i;
            we_reg     <= req_we_i;
        end
        if (state_reg == SPLIT) begin
            lo_reg <= rd_word_reg;
        end
    end

    assign pair_shifted = {rd_word_reg, lo_reg} >> {off_reg, 3'b000};
    assign load_word    = (off_reg == 3'd0) ? rd_word_reg : pair_shifted[63:0];
`else
    assign load_word    = rd_word_reg;
`endif

    // Port control: accept-edge access to the low word, SPLIT-cycle access to the high word.
    always_comb begin
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_idx  = req_word;
        rd_idx  = req_word;
        wr_mask = ~64'd0 << req_shift;
        wr_data = req_wdata_i << req_shift;
        if (accept && !req_error) begin
            wr_en = req_we_i;
            rd_en = !req_we_i;
        end
`ifdef Y86_DMEM_MISALIGN_EN
        if (state_reg == SPLIT) begin
            wr_en   = we_reg;
            rd_en   = !we_reg;
            wr_idx  = hi_idx_reg;
            rd_idx  = hi_idx_reg;
            wr_mask = ~(~64'd0 << {off_reg, 3'b000});
            wr_data = wdata_reg >> (7'd64 - {1'b0, off_reg, 3'b000});
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
        end
        if (rd_en) begin
            rd_word_reg <= mem[rd_idx];
        end
    end

    assign rsp_valid_o = rsp_valid_reg;
    assign rsp_error_o = rsp_error_reg;
    assign rsp_rdata_o = load_ok_reg ? load_word : 64'd0;
endmodule
